// File: rtl/cv32e41s_pkg.sv
// Shared types for the MPU error queue: response status codes and the
// tracking entry {err, we} kept per outstanding transaction.
package cv32e41s_pkg;

  typedef enum logic [1:0] {
    MPU_OK       = 2'b00,
    MPU_RE_FAULT = 2'b01,
    MPU_WR_FAULT = 2'b10
  } mpu_status_e;

  typedef struct packed {
    logic err;
    logic we;
  } mpu_errq_entry_t;

endpackage

// File: rtl/cv32e41s_mpu_errq_fifo.sv
// In-order tracking FIFO of DEPTH {err,we} entries.
// Ports: i_push/i_pop/i_data in; o_full/o_empty/o_count/o_head/o_err_any out.
module cv32e41s_mpu_errq_fifo
  import cv32e41s_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int CW    = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_push,
  input  logic            i_pop,
  input  mpu_errq_entry_t i_data,
  output logic            o_full,
  output logic            o_empty,
  output logic [CW-1:0]   o_count,
  output mpu_errq_entry_t o_head,
  output logic            o_err_any
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  mpu_errq_entry_t  r_mem [DEPTH];
  logic [DEPTH-1:0] r_vld;
  logic [PW-1:0]    r_wptr;
  logic [PW-1:0]    r_rptr;
  logic [CW-1:0]    r_cnt;
  logic [DEPTH-1:0] w_vld_nxt;
  logic [DEPTH-1:0] w_err_vec;

  function automatic logic [PW-1:0] f_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // Per-slot valid bits make "any queued error" a simple OR.
  always_comb begin
    w_vld_nxt = r_vld;
    if (i_pop)  w_vld_nxt[r_rptr] = 1'b0;
    if (i_push) w_vld_nxt[r_wptr] = 1'b1;
  end

  always_comb begin
    w_err_vec = '0;
    for (int i = 0; i < DEPTH; i++)
      w_err_vec[i] = r_vld[i] & r_mem[i].err;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
      r_vld  <= '0;
    end else begin
      if (i_push) r_wptr <= f_inc(r_wptr);
      if (i_pop)  r_rptr <= f_inc(r_rptr);
      r_cnt <= r_cnt + CW'(i_push) - CW'(i_pop);
      r_vld <= w_vld_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (i_push && !rst) r_mem[r_wptr] <= i_data;
  end

  assign o_full    = (r_cnt == CW'(DEPTH));
  assign o_empty   = (r_cnt == '0);
  assign o_count   = r_cnt;
  assign o_head    = r_mem[r_rptr];
  assign o_err_any = |w_err_vec;

endmodule

// File: rtl/cv32e41s_mpu_errq.sv
// MPU error queue: forwards fault-free requests to the bus and answers
// faulting ones locally, keeping all responses in request order.
// Ports: core req/resp, bus req/resp, mpu_err_i, status/outstanding/errors.
// Optional fault counter enabled by CV32E41S_MPU_ERRQ_CNT_EN.
module cv32e41s_mpu_errq
  import cv32e41s_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int REQ_W = 64,
  parameter int RSP_W = 33
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       core_trans_valid_i,
  output logic                       core_trans_ready_o,
  input  logic [REQ_W-1:0]           core_trans_i,
  input  logic                       core_trans_we_i,
  input  logic                       mpu_err_i,
  output logic                       bus_trans_valid_o,
  input  logic                       bus_trans_ready_i,
  output logic [REQ_W-1:0]           bus_trans_o,
  input  logic                       bus_resp_valid_i,
  input  logic [RSP_W-1:0]           bus_resp_i,
  output logic                       core_resp_valid_o,
  output logic [RSP_W-1:0]           core_resp_o,
  output logic [1:0]                 core_resp_status_o,
  output logic                       core_mpu_err_o,
  output logic [$clog2(DEPTH+1)-1:0] outstanding_o,
  output logic                       resp_unexpected_o,
  output logic [15:0]                err_cnt_o
);

  localparam int CW = $clog2(DEPTH + 1);

  mpu_errq_entry_t w_head;
  mpu_errq_entry_t w_entry;
  logic            w_full;
  logic            w_empty;
  logic            w_err_pend;
  logic            w_push;
  logic            w_pop;
  logic            w_err_rsp;
  logic            w_ok_rsp;
  logic            r_unexp;

  assign w_entry = '{err: mpu_err_i, we: core_trans_we_i};

  cv32e41s_mpu_errq_fifo #(
    .DEPTH (DEPTH),
    .CW    (CW)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .i_push    (w_push),
    .i_pop     (w_pop),
    .i_data    (w_entry),
    .o_full    (w_full),
    .o_empty   (w_empty),
    .o_count   (outstanding_o),
    .o_head    (w_head),
    .o_err_any (w_err_pend)
  );

  // A queued fault blocks clean traffic so the fault is answered in order.
  assign core_trans_ready_o = !w_full &&
    (mpu_err_i || (bus_trans_ready_i && !w_err_pend));
  assign w_push = core_trans_valid_i && core_trans_ready_o;

  assign bus_trans_valid_o = core_trans_valid_i && !mpu_err_i &&
    !w_full && !w_err_pend;
  assign bus_trans_o    = core_trans_i;
  assign core_mpu_err_o = core_trans_valid_i && mpu_err_i;

  assign w_err_rsp = !w_empty && w_head.err;
  assign w_ok_rsp  = !w_empty && !w_head.err && bus_resp_valid_i;
  assign w_pop     = !rst && (w_err_rsp || w_ok_rsp);

  assign core_resp_valid_o  = w_pop;
  assign core_resp_o        = w_ok_rsp ? bus_resp_i : '0;
  assign core_resp_status_o = !w_err_rsp ? MPU_OK :
    (w_head.we ? MPU_WR_FAULT : MPU_RE_FAULT);

  // Bus data with no clean head to match is dropped and flagged.
  always_ff @(posedge clk) begin
    if (rst) r_unexp <= 1'b0;
    else if (bus_resp_valid_i && (w_empty || w_head.err))
      r_unexp <= 1'b1;
  end

  assign resp_unexpected_o = r_unexp;

`ifdef CV32E41S_MPU_ERRQ_CNT_EN
  logic [15:0] r_err_cnt;

  always_ff @(posedge clk) begin
    if (rst) r_err_cnt <= '0;
    else if (w_push && mpu_err_i && r_err_cnt != 16'hFFFF)
      r_err_cnt <= r_err_cnt + 16'd1;
  end

  assign err_cnt_o = r_err_cnt;
`else
  assign err_cnt_o = 16'h0;
`endif

endmodule

// File: tb/tb_cv32e41s_mpu_errq.sv
// Random-stimulus bench for cv32e41s_mpu_errq against a queue-based
// reference model of the in-order error queue.
module tb_cv32e41s_mpu_errq;

  localparam int DEPTH = 2;
  localparam int REQ_W = 64;
  localparam int RSP_W = 33;
  localparam int CW    = $clog2(DEPTH + 1);

  logic             clk = 1'b0;
  logic             rst;
  logic             cv, we, mpu, bready, brv;
  logic [REQ_W-1:0] req;
  logic [RSP_W-1:0] brsp;
  logic             ready, bvalid, rvalid, merr, unexp;
  logic [REQ_W-1:0] btrans;
  logic [RSP_W-1:0] rsp;
  logic [1:0]       status;
  logic [CW-1:0]    outst;
  logic [15:0]      ecnt;

  int n_chk  = 0;
  int n_pass = 0;

  cv32e41s_mpu_errq #(
    .DEPTH (DEPTH),
    .REQ_W (REQ_W),
    .RSP_W (RSP_W)
  ) dut (
    .clk                (clk),
    .rst                (rst),
    .core_trans_valid_i (cv),
    .core_trans_ready_o (ready),
    .core_trans_i       (req),
    .core_trans_we_i    (we),
    .mpu_err_i          (mpu),
    .bus_trans_valid_o  (bvalid),
    .bus_trans_ready_i  (bready),
    .bus_trans_o        (btrans),
    .bus_resp_valid_i   (brv),
    .bus_resp_i         (brsp),
    .core_resp_valid_o  (rvalid),
    .core_resp_o        (rsp),
    .core_resp_status_o (status),
    .core_mpu_err_o     (merr),
    .outstanding_o      (outst),
    .resp_unexpected_o  (unexp),
    .err_cnt_o          (ecnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // Model: queue of {err,we} per outstanding request.
  logic [1:0] q[$];
  bit         m_unexp;
  int         m_cnt;

  initial begin
    bit e_full, e_errp, e_ready, e_push, e_rv, h_err, h_we;
    rst = 1'b1; cv = 0; we = 0; mpu = 0; bready = 0; brv = 0;
    req = '0; brsp = '0;
    m_unexp = 0; m_cnt = 0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_outst", 64'(outst), 0);
    chk("rst_unexp", 64'(unexp), 0);
    chk("rst_cnt", 64'(ecnt), 0);
    chk("rst_rvalid", 64'(rvalid), 0);

    for (int cyc = 0; cyc < 4000; cyc++) begin
      @(posedge clk); #1;
      rst    = ($urandom_range(0, 79) == 0);
      cv     = ($urandom_range(0, 3) != 0);
      mpu    = ($urandom_range(0, 3) == 0);
      we     = $urandom_range(0, 1);
      bready = ($urandom_range(0, 2) != 0);
      req    = {$urandom, $urandom};
      brsp   = RSP_W'({$urandom, $urandom});
      h_err  = (q.size() > 0) ? q[0][1] : 1'b0;
      h_we   = (q.size() > 0) ? q[0][0] : 1'b0;
      if (q.size() > 0 && !h_err) brv = $urandom_range(0, 1);
      else brv = ($urandom_range(0, 39) == 0);

      e_full  = (q.size() == DEPTH);
      e_errp  = 0;
      foreach (q[i]) if (q[i][1]) e_errp = 1;
      e_ready = !e_full && (mpu || (bready && !e_errp));
      e_push  = cv && e_ready;
      e_rv    = !rst && q.size() > 0 && (h_err || brv);

      @(negedge clk);
      chk("ready", 64'(ready), 64'(e_ready));
      chk("bvalid", 64'(bvalid), 64'(cv && !mpu && !e_full && !e_errp));
      if (bvalid) chk("btrans", btrans, req);
      chk("mpu_err", 64'(merr), 64'(cv && mpu));
      chk("outst", 64'(outst), 64'(q.size()));
      chk("unexp", 64'(unexp), 64'(m_unexp));
      chk("err_cnt", 64'(ecnt), 64'(m_cnt));
      chk("rvalid", 64'(rvalid), 64'(e_rv));
      if (e_rv) begin
        chk("rsp", 64'(rsp), h_err ? 64'd0 : 64'(brsp));
        chk("status", 64'(status),
            !h_err ? 64'd0 : (h_we ? 64'd2 : 64'd1));
      end

      if (rst) begin
        q.delete();
        m_unexp = 0;
        m_cnt = 0;
      end else begin
        if (brv && (q.size() == 0 || h_err)) m_unexp = 1;
        if (e_rv) void'(q.pop_front());
        if (e_push) begin
          q.push_back({mpu, we});
`ifdef CV32E41S_MPU_ERRQ_CNT_EN
          if (mpu && m_cnt < 65535) m_cnt++;
`endif
        end
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/cv32e41s_mpu_errq.md
CV32E41S_MPU_ERRQ -- requirements
Module: cv32e41s_mpu_errq

Interface
REQ-001 SHALL have parameter DEPTH, default 2: maximum outstanding transactions, bus plus error (legal 1..8).
REQ-002 SHALL have parameter REQ_W, default 64: opaque request payload width.
REQ-003 SHALL have parameter RSP_W, default 33: opaque response payload width.
REQ-004 SHALL have port clk  in  1: single clock; one clock, all logic on rising edge.
REQ-005 SHALL have port rst  in  1: reset, synchronous and active-high.
REQ-006 SHALL have ports core_trans_valid_i in 1, core_trans_ready_o out 1, core_trans_i in REQ_W, core_trans_we_i in 1: core request handshake.
REQ-007 SHALL have port mpu_err_i  in  1: combined PMA/PMP fault for the current core_trans_i.
REQ-008 SHALL have ports bus_trans_valid_o out 1, bus_trans_ready_i in 1, bus_trans_o out REQ_W: bus request.
REQ-009 SHALL have ports bus_resp_valid_i in 1, bus_resp_i in RSP_W: bus response, in order, no backpressure.
REQ-010 SHALL have ports core_resp_valid_o out 1, core_resp_o out RSP_W, core_resp_status_o out 2: response to core.
REQ-011 SHALL have ports core_mpu_err_o out 1, outstanding_o out $clog2(DEPTH+1), resp_unexpected_o out 1, err_cnt_o out 16.

Function
REQ-012 SHALL keep an in-order tracking FIFO of DEPTH entries {err, we}; count = outstanding_o.
REQ-013 Accept = core_trans_valid_i && core_trans_ready_o; each accept SHALL push one entry.
REQ-014 core_trans_ready_o SHALL be: count<DEPTH && (mpu_err_i || (bus_trans_ready_i && !err_pending)); no same-cycle push-when-full even if popping.
REQ-015 err_pending SHALL be 1 while any FIFO entry has err=1; while set, fault-free requests are stalled, faulting requests still queue.
REQ-016 bus_trans_valid_o SHALL = core_trans_valid_i && !mpu_err_i && count<DEPTH && !err_pending; bus_trans_o = core_trans_i.
REQ-017 core_mpu_err_o SHALL = core_trans_valid_i && mpu_err_i, combinational.
REQ-018 Head err=0: on bus_resp_valid_i SHALL assert core_resp_valid_o same cycle, core_resp_o=bus_resp_i, status 2'b00 (OK), pop.
REQ-019 Head err=1: SHALL assert core_resp_valid_o, core_resp_o='0, status 2'b01 (RE_FAULT) if we=0 else 2'b10 (WR_FAULT), pop; minimum latency one cycle after push.
REQ-020 Core SHALL be assumed always ready for responses; exactly one response per cycle maximum.
REQ-021 bus_resp_valid_i with FIFO empty or head err=1 SHALL set resp_unexpected_o sticky, drop the response, pop nothing.
REQ-022 Simultaneous push and pop SHALL leave count unchanged; pointers wrap modulo DEPTH.
REQ-023 A pushed error entry SHALL not be responded before all older bus entries have responded (in-order).

Reset
REQ-024 On rst: FIFO empty, count 0, resp_unexpected_o 0, err_cnt_o 0, core_resp_valid_o 0; in-flight bus transactions SHALL be forgotten (responses after reset flag resp_unexpected_o).
REQ-025 Reset SHALL take priority over any same-cycle push/pop.

Configuration
REQ-026 With CV32E41S_MPU_ERRQ_CNT_EN defined: err_cnt_o increments on every faulting accept, saturating at 16'hFFFF.
REQ-027 Without CV32E41S_MPU_ERRQ_CNT_EN: err_cnt_o tied to 16'h0, no counter flops.

Structure
REQ-028 mpu_status encodings (OK/RE_FAULT/WR_FAULT) and the entry struct SHALL live in cv32e41s_pkg.
REQ-029 FIFO SHALL be sub-module cv32e41s_mpu_errq_fifo (push, pop, full, empty, count, head).

Verification
REQ-030 DEPTH=2: two clean reads accepted, bus_resp on cycles 3,4 -> two OK responses in order, outstanding_o 0.
REQ-031 Read to clean addr then faulting write: fault queued (count 2), clean stalled; bus_resp -> OK, next cycle status 2'b10.
REQ-032 Empty FIFO, faulting read at cycle 0 -> core_resp_valid_o at cycle 1, status 2'b01, core_mpu_err_o high at cycle 0.
REQ-033 DEPTH=2 full, third request -> core_trans_ready_o 0 until a pop, then accepted the following cycle.
REQ-034 bus_resp_valid_i with empty FIFO -> resp_unexpected_o 1 and held until rst.
REQ-035 CNT_EN defined, 3 faulting accepts -> err_cnt_o 3; rst -> 0; without macro -> always 0.
